// File: rtl/start_ctrl_pkg.sv
// start_ctrl shared types: FSM states, default clear depths, counter width.
// Watchdog feature is selected by START_CTRL_WATCHDOG_EN.
package start_ctrl_pkg;

  localparam int DM_DEPTH_DEF = 256;
  localparam int RF_DEPTH_DEF = 16;
  localparam int CNT_W        = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ARMED = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic is_busy(state_t s);
    return (s == S_CLEAR) || (s == S_RUN);
  endfunction

endpackage

// File: rtl/start_ctrl_run_counter.sv
// run_counter: saturating run-cycle counter, zeroed on clear,
// advanced on enable, held otherwise.
module run_counter
  import start_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] CMAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != CMAX) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/start_ctrl.sv
// start_ctrl: holds the core, clears DM/RF, launches on start fall.
// Optional run watchdog under START_CTRL_WATCHDOG_EN.
module start_ctrl
  import start_ctrl_pkg::*;
#(
  parameter int DM_DEPTH   = DM_DEPTH_DEF,
  parameter int RF_DEPTH   = RF_DEPTH_DEF,
  parameter int W          = 8,
  parameter int MAX_CYCLES = 50000
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        start,
  input  logic                        core_halt,
  output logic                        core_start,
  output logic                        dm_we,
  output logic [$clog2(DM_DEPTH)-1:0] dm_addr,
  output logic [W-1:0]                dm_wdata,
  output logic                        rf_we,
  output logic [$clog2(RF_DEPTH)-1:0] rf_addr,
  output logic [W-1:0]                rf_wdata,
  output logic                        halt,
  output logic [CNT_W-1:0]            cycle_count,
  output logic                        busy
`ifdef START_CTRL_WATCHDOG_EN
  ,
  output logic                        timeout
`endif
);

  localparam int DAW = $clog2(DM_DEPTH);
  localparam int RAW = $clog2(RF_DEPTH);
  localparam logic [DAW-1:0] LAST = DAW'(DM_DEPTH - 1);

  state_t         state;
  state_t         nxt;
  logic [DAW-1:0] nidx;
  logic           last;
  logic           wd_hit;
  logic           run_entry;
  logic           run_en;

  assign dm_wdata = '0;
  assign rf_wdata = '0;
  assign last     = (dm_addr == LAST);

`ifdef START_CTRL_WATCHDOG_EN
  assign wd_hit = (state == S_RUN) &&
                  (32'(cycle_count) + 1 >= MAX_CYCLES);
`else
  logic unused_wd;
  assign unused_wd = (MAX_CYCLES == 0);
  assign wd_hit    = 1'b0;
`endif

  // start has priority over core_halt, which beats the watchdog
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  if (start) nxt = S_CLEAR;
      S_CLEAR: if (last) nxt = start ? S_ARMED : S_RUN;
      S_ARMED: if (!start) nxt = S_RUN;
      S_RUN: begin
        if (start)          nxt = S_CLEAR;
        else if (core_halt) nxt = S_DONE;
        else if (wd_hit)    nxt = S_DONE;
      end
      S_DONE:  if (start) nxt = S_CLEAR;
      default: nxt = S_IDLE;
    endcase
  end

  always_comb begin
    nidx = '0;
    if (state == S_CLEAR && nxt == S_CLEAR) begin
      nidx = dm_addr + 1'b1;
    end
  end

  assign run_entry = (nxt == S_RUN) && (state != S_RUN);
  assign run_en    = (state == S_RUN);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= S_IDLE;
      core_start <= 1'b1;
      halt       <= 1'b0;
      busy       <= 1'b0;
      dm_we      <= 1'b0;
      dm_addr    <= '0;
      rf_we      <= 1'b0;
      rf_addr    <= '0;
    end else begin
      state      <= nxt;
      core_start <= (nxt != S_RUN);
      halt       <= (nxt == S_DONE);
      busy       <= is_busy(nxt);
      dm_we      <= (nxt == S_CLEAR);
      dm_addr    <= nidx;
      if (nxt == S_CLEAR && 32'(nidx) < RF_DEPTH) begin
        rf_we   <= 1'b1;
        rf_addr <= RAW'(nidx);
      end else begin
        rf_we   <= 1'b0;
        rf_addr <= '0;
      end
    end
  end

`ifdef START_CTRL_WATCHDOG_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      timeout <= 1'b0;
    end else if (nxt == S_CLEAR && state != S_CLEAR) begin
      timeout <= 1'b0;
    end else if (state == S_RUN && nxt == S_DONE &&
                 !core_halt) begin
      timeout <= 1'b1;
    end
  end
`endif

  run_counter u_cnt (
    .clk    (CLK),
    .rst_n  (RST_N),
    .clear  (run_entry),
    .enable (run_en),
    .count  (cycle_count)
  );

endmodule
